// File: rtl/alu_sequencer.sv
// alu_sequencer
// Control sequencer for the RISC datapath. It latches one 16-bit instruction
// and steps the register file and execute stage through the operand read,
// ALU/shift and write-back cycles that instruction needs. Each instruction
// completes before the next one is accepted.
//
// Ports
//   i_clk       rising-edge clock
//   i_resetn    synchronous active-low reset
//   i_s         start request, only looked at while idle (WAIT)
//   i_instr     instruction word, captured on the accepting edge
//   o_w         1 while idle and ready for a new instruction
//   o_readnum   register-file read select
//   o_writenum  register-file write select
//   o_write     register-file write enable
//   o_vsel      write-back source: 00 = C result, 01 = sximm8
//   o_loada     A operand register load
//   o_loadb     B operand register load
//   o_asel      1 forces the ALU A input to zero
//   o_bsel      reserved, always 0
//   o_shift     shifter control
//   o_ALUop     00 ADD, 01 CMP/SUB, 10 AND, 11 MVN
//   o_loadc     C result register load
//   o_loads     status register load
//   o_sximm8    sign-extended low byte of the latched instruction
module alu_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_resetn,
  input  logic             i_s,
  input  logic [WIDTH-1:0] i_instr,
  output logic             o_w,
  output logic [2:0]       o_readnum,
  output logic [2:0]       o_writenum,
  output logic             o_write,
  output logic [1:0]       o_vsel,
  output logic             o_loada,
  output logic             o_loadb,
  output logic             o_asel,
  output logic             o_bsel,
  output logic [1:0]       o_shift,
  output logic [1:0]       o_ALUop,
  output logic             o_loadc,
  output logic             o_loads,
  output logic [WIDTH-1:0] o_sximm8
);

  typedef enum logic [2:0] {
    S_WAIT      = 3'd0,
    S_DECODE    = 3'd1,
    S_GET_A     = 3'd2,
    S_GET_B     = 3'd3,
    S_EXEC      = 3'd4,
    S_WRITE_REG = 3'd5,
    S_WRITE_IMM = 3'd6
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_ir;

  logic             r_w;
  logic [2:0]       r_readnum;
  logic [2:0]       r_writenum;
  logic             r_write;
  logic [1:0]       r_vsel;
  logic             r_loada;
  logic             r_loadb;
  logic             r_asel;
  logic [1:0]       r_shift;
  logic [1:0]       r_aluOp;
  logic             r_loadc;
  logic             r_loads;

  // Instruction fields decoded from the latched instruction register.
  logic [2:0] w_opcode;
  logic [1:0] w_op;
  logic [2:0] w_rn;
  logic [2:0] w_rd;
  logic [1:0] w_sh;
  logic [2:0] w_rm;
  logic       w_isMovImm;
  logic       w_isMovReg;
  logic       w_isAlu;
  logic       w_isCmp;

  assign w_opcode   = r_ir[15:13];
  assign w_op       = r_ir[12:11];
  assign w_rn       = r_ir[10:8];
  assign w_rd       = r_ir[7:5];
  assign w_sh       = r_ir[4:3];
  assign w_rm       = r_ir[2:0];
  assign w_isMovImm = (w_opcode == 3'b110) && (w_op == 2'b10);
  assign w_isMovReg = (w_opcode == 3'b110) && (w_op == 2'b00);
  assign w_isAlu    = (w_opcode == 3'b101);
  assign w_isCmp    = w_isAlu && (w_op == 2'b01);

  // The strobes are registered: every transition below loads the output
  // registers with the values belonging to the state being entered, so the
  // outputs always match r_state and never see i_s or i_instr directly.
  // Every strobe defaults to 0 and each branch raises only what the
  // destination state needs. Reset wins over a start request.
  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_state    <= S_WAIT;
      r_ir       <= '0;
      r_w        <= 1'b1;
      r_readnum  <= 3'b000;
      r_writenum <= 3'b000;
      r_write    <= 1'b0;
      r_vsel     <= 2'b00;
      r_loada    <= 1'b0;
      r_loadb    <= 1'b0;
      r_asel     <= 1'b0;
      r_shift    <= 2'b00;
      r_aluOp    <= 2'b00;
      r_loadc    <= 1'b0;
      r_loads    <= 1'b0;
    end else begin
      r_w        <= 1'b0;
      r_readnum  <= 3'b000;
      r_writenum <= 3'b000;
      r_write    <= 1'b0;
      r_vsel     <= 2'b00;
      r_loada    <= 1'b0;
      r_loadb    <= 1'b0;
      r_asel     <= 1'b0;
      r_shift    <= 2'b00;
      r_aluOp    <= 2'b00;
      r_loadc    <= 1'b0;
      r_loads    <= 1'b0;

      case (r_state)
        S_WAIT: begin
          if (i_s) begin
            r_ir    <= i_instr;
            r_state <= S_DECODE;
          end else begin
            r_w     <= 1'b1;
            r_state <= S_WAIT;
          end
        end

        // An unsupported opcode/op pair goes straight back to idle
        // without raising any strobe.
        S_DECODE: begin
          if (w_isMovImm) begin
            r_state    <= S_WRITE_IMM;
            r_write    <= 1'b1;
            r_writenum <= w_rn;
            r_vsel     <= 2'b01;
          end else if (w_isMovReg) begin
            r_state   <= S_GET_B;
            r_readnum <= w_rm;
            r_loadb   <= 1'b1;
          end else if (w_isAlu) begin
            r_state   <= S_GET_A;
            r_readnum <= w_rn;
            r_loada   <= 1'b1;
          end else begin
            r_state <= S_WAIT;
            r_w     <= 1'b1;
          end
        end

        S_GET_A: begin
          r_state   <= S_GET_B;
          r_readnum <= w_rm;
          r_loadb   <= 1'b1;
        end

        // Register moves reuse the ALU as a pass-through: A is forced to
        // zero and the shifted B is added to it.
        S_GET_B: begin
          r_state <= S_EXEC;
          r_loadc <= 1'b1;
          r_shift <= w_sh;
          r_asel  <= !w_isAlu;
          r_aluOp <= w_isAlu ? w_op : 2'b00;
          r_loads <= w_isCmp;
        end

        // A compare only updates status, so it has nothing to write back.
        S_EXEC: begin
          if (w_isCmp) begin
            r_state <= S_WAIT;
            r_w     <= 1'b1;
          end else begin
            r_state    <= S_WRITE_REG;
            r_write    <= 1'b1;
            r_writenum <= w_rd;
            r_vsel     <= 2'b00;
          end
        end

        S_WRITE_REG, S_WRITE_IMM: begin
          r_state <= S_WAIT;
          r_w     <= 1'b1;
        end

        default: begin
          r_state <= S_WAIT;
          r_w     <= 1'b1;
        end
      endcase
    end
  end

  assign o_w        = r_w;
  assign o_readnum  = r_readnum;
  assign o_writenum = r_writenum;
  assign o_write    = r_write;
  assign o_vsel     = r_vsel;
  assign o_loada    = r_loada;
  assign o_loadb    = r_loadb;
  assign o_asel     = r_asel;
  assign o_bsel     = 1'b0;
  assign o_shift    = r_shift;
  assign o_ALUop    = r_aluOp;
  assign o_loadc    = r_loadc;
  assign o_loads    = r_loads;
  assign o_sximm8   = {{(WIDTH-8){r_ir[7]}}, r_ir[7:0]};

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer
// Drives a table of instructions through alu_sequencer. For every accepted
// instruction a reference model expands the instruction into the sequence of
// output words expected after each clock edge and pushes them onto a queue;
// each cycle the oldest expected word is popped and compared with the DUT.
// Hand-written sequences cover back-to-back starts and reset mid-instruction.
module tb_alu_sequencer;

  typedef struct packed {
    logic        w;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic [1:0]  vsel;
    logic        loada;
    logic        loadb;
    logic        asel;
    logic        bsel;
    logic [1:0]  shift;
    logic [1:0]  aluOp;
    logic        loadc;
    logic        loads;
    logic [15:0] sximm8;
  } outs_t;

  typedef struct {
    logic [15:0] instr;
    int          expLen;
    string       name;
  } vec_t;

  logic        clk;
  logic        resetn;
  logic        s;
  logic [15:0] instr;
  logic        w;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic        write;
  logic [1:0]  vsel;
  logic        loada;
  logic        loadb;
  logic        asel;
  logic        bsel;
  logic [1:0]  shift;
  logic [1:0]  aluOp;
  logic        loadc;
  logic        loads;
  logic [15:0] sximm8;

  int checks;
  int errors;
  outs_t expQ[$];
  vec_t  vecs[11];

  alu_sequencer #(.WIDTH(16)) dut (
    .i_clk      (clk),
    .i_resetn   (resetn),
    .i_s        (s),
    .i_instr    (instr),
    .o_w        (w),
    .o_readnum  (readnum),
    .o_writenum (writenum),
    .o_write    (write),
    .o_vsel     (vsel),
    .o_loada    (loada),
    .o_loadb    (loadb),
    .o_asel     (asel),
    .o_bsel     (bsel),
    .o_shift    (shift),
    .o_ALUop    (aluOp),
    .o_loadc    (loadc),
    .o_loads    (loads),
    .o_sximm8   (sximm8)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: expected output words after edge 0 (DECODE) through
  // the edge that returns to WAIT, built from the instruction semantics.
  task automatic pushExpected(input logic [15:0] ins);
    outs_t base;
    outs_t r;
    logic [2:0] opc;
    logic [1:0] op;
    logic       movImm;
    logic       movReg;
    logic       alu;
    logic       cmp;
    opc    = ins[15:13];
    op     = ins[12:11];
    movImm = (opc == 3'b110) && (op == 2'b10);
    movReg = (opc == 3'b110) && (op == 2'b00);
    alu    = (opc == 3'b101);
    cmp    = alu && (op == 2'b01);
    base = '0;
    base.sximm8 = {{8{ins[7]}}, ins[7:0]};
    r = base;
    expQ.push_back(r);
    if (movImm) begin
      r = base; r.write = 1'b1; r.writenum = ins[10:8]; r.vsel = 2'b01;
      expQ.push_back(r);
    end else if (movReg || alu) begin
      if (alu) begin
        r = base; r.readnum = ins[10:8]; r.loada = 1'b1;
        expQ.push_back(r);
      end
      r = base; r.readnum = ins[2:0]; r.loadb = 1'b1;
      expQ.push_back(r);
      r = base; r.loadc = 1'b1; r.shift = ins[4:3]; r.asel = !alu;
      r.aluOp = alu ? op : 2'b00; r.loads = cmp;
      expQ.push_back(r);
      if (!cmp) begin
        r = base; r.write = 1'b1; r.writenum = ins[7:5]; r.vsel = 2'b00;
        expQ.push_back(r);
      end
    end
    r = base; r.w = 1'b1;
    expQ.push_back(r);
  endtask

  task automatic pushReset();
    outs_t r;
    r = '0;
    r.w = 1'b1;
    expQ.push_back(r);
  endtask

  // Pops the oldest expected word and compares it with the DUT outputs.
  task automatic checkOutput(input string name, input int cyc);
    outs_t act;
    outs_t exp;
    act = '{w: w, readnum: readnum, writenum: writenum, write: write,
            vsel: vsel, loada: loada, loadb: loadb, asel: asel, bsel: bsel,
            shift: shift, aluOp: aluOp, loadc: loadc, loads: loads,
            sximm8: sximm8};
    checks++;
    if (expQ.size() == 0) begin
      errors++;
      $display("[TB] FAIL %s cyc %0d: scoreboard empty, act=%h", name, cyc, act);
    end else begin
      exp = expQ.pop_front();
      if (act !== exp) begin
        errors++;
        $display("[TB] FAIL %s cyc %0d: act=%h exp=%h", name, cyc, act, exp);
      end
    end
  endtask

  // Called at a falling edge with the DUT idle. Starts one instruction and
  // checks every cycle until the expected sequence is exhausted. With
  // holdS the start request stays high throughout (it must be ignored while
  // busy); otherwise it is dropped and instr is scrambled after edge 0.
  task automatic applyStimulus(input vec_t v, input bit holdS);
    int edges;
    int wEdge;
    instr = v.instr;
    s = 1'b1;
    pushExpected(v.instr);
    edges = 0;
    wEdge = -1;
    while (expQ.size() > 0 && edges < 20) begin
      @(posedge clk);
      #1;
      edges++;
      if (!holdS) begin
        s = 1'b0;
        instr = 16'($urandom);
      end
      @(negedge clk);
      checkOutput(v.name, edges - 1);
      if (w && wEdge < 0) wEdge = edges - 1;
    end
    checks++;
    if (wEdge != v.expLen) begin
      errors++;
      $display("[TB] FAIL %s latency: w returned after edge %0d, expected %0d",
               v.name, wEdge, v.expLen);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    vecs[0]  = '{16'hD2F6, 2, "movImmNeg"};
    vecs[1]  = '{16'hA0A1, 5, "addR5R0R1"};
    vecs[2]  = '{16'hA901, 4, "cmpR1R1"};
    vecs[3]  = '{16'hC0F3, 4, "movRegSh10"};
    vecs[4]  = '{16'hE000, 1, "illegalE000"};
    vecs[5]  = '{16'hB2E7, 5, "andR7R2R7"};
    vecs[6]  = '{16'hB8C9, 5, "mvnSh01"};
    vecs[7]  = '{16'hD07F, 2, "movImmPos"};
    vecs[8]  = '{16'hC800, 1, "illegalOp01"};
    vecs[9]  = '{16'h0000, 1, "illegalZero"};
    vecs[10] = '{16'hA8FF, 4, "cmpSh11"};

    resetn = 1'b0;
    s = 1'b0;
    instr = 16'h0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    pushReset();
    checkOutput("resetState", 0);
    resetn = 1'b1;

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i], 1'b0);
    end

    // Start held high: each instruction is accepted on the first edge that
    // finds WAIT, with s ignored while busy.
    $display("[TB] back-to-back starts");
    applyStimulus(vecs[2], 1'b1);
    applyStimulus(vecs[0], 1'b1);
    applyStimulus(vecs[1], 1'b1);
    s = 1'b0;

    // Reset during GET_B of an ADD: the write-back must be abandoned and
    // reset must win over a simultaneous start.
    $display("[TB] reset mid-instruction");
    instr = 16'hA0A1;
    s = 1'b1;
    pushExpected(16'hA0A1);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      s = 1'b0;
      @(negedge clk);
      checkOutput("rstPre", c);
    end
    expQ.delete();
    resetn = 1'b0;
    s = 1'b1;
    instr = 16'hD2F6;
    for (int c = 0; c < 2; c++) begin
      pushReset();
      @(posedge clk);
      @(negedge clk);
      checkOutput("rstMid", c);
    end
    resetn = 1'b1;
    s = 1'b0;
    for (int c = 0; c < 2; c++) begin
      pushReset();
      @(posedge clk);
      @(negedge clk);
      checkOutput("rstIdle", c);
    end
    applyStimulus(vecs[3], 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
